// File: rtl/cpu_pkg.sv
// Constants shared by the fetch stage and the control unit of the pipelined MIPS core.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and a synchronous memory (slave).
// en high in cycle N requests word addr; rdata carries that word during cycle N+1 (no back-pressure).
interface if_fetch_stage_if #(
    parameter int IMEM_AW = 8
);
    logic               en;
    logic [IMEM_AW-1:0] addr;
    logic [31:0]        rdata;

    modport master (output en, output addr, input rdata);
    modport slave  (input en, input addr, output rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction that IF/ID could not take.
// flush wins over load, load wins over drain.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= 32'h0;
            pc4   <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= in_instr;
            pc4   <= in_pc4;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, 1-cycle-latency memory issue, IF/ID register with a one-entry skid
// buffer for decode stalls, and redirect handling that flushes wrong-path fetches.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IMEM_AW  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    if_fetch_stage_if.master         imem,
    input  logic                     id_stall,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_target,
    output logic                     if_id_valid,
    output logic [31:0]              if_id_instr,
    output logic [31:0]              if_id_pc4
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inflight;
    logic [31:0] inflight_pc4;
    logic        issue;
    logic        can_load;
    logic        sk_valid;
    logic [31:0] sk_instr;
    logic [31:0] sk_pc4;
    logic        sk_load;
    logic        sk_drain;

    assign pc_plus4 = pc + 32'd4;

    // Stop issuing while anything is parked, so at most one response ever needs the skid entry.
    assign issue     = rst_n && !id_stall && !sk_valid && !redirect_valid;
    assign imem.en   = issue;
    assign imem.addr = pc[IMEM_AW+1:2];

    assign can_load = !id_stall || !if_id_valid;
    assign sk_load  = !redirect_valid && inflight && !can_load;
    assign sk_drain = !redirect_valid && can_load && sk_valid;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sk_load),
        .drain    (sk_drain),
        .flush    (redirect_valid),
        .in_instr (imem.rdata),
        .in_pc4   (inflight_pc4),
        .valid    (sk_valid),
        .instr    (sk_instr),
        .pc4      (sk_pc4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= PC_RESET;
            inflight     <= 1'b0;
            inflight_pc4 <= 32'h0;
            if_id_valid  <= 1'b0;
            if_id_instr  <= NOP_INSTR;
            if_id_pc4    <= 32'h0;
        end else if (redirect_valid) begin
            // Drops the returning response, the skid entry and IF/ID in one go.
            pc          <= redirect_target & 32'hFFFF_FFFC;
            inflight    <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'h0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc           <= pc_plus4;
                inflight_pc4 <= pc_plus4;
            end
            if (can_load) begin
                if (sk_valid) begin
                    if_id_valid <= 1'b1;
                    if_id_instr <= sk_instr;
                    if_id_pc4   <= sk_pc4;
                end else if (inflight) begin
                    if_id_valid <= 1'b1;
                    if_id_instr <= imem.rdata;
                    if_id_pc4   <= inflight_pc4;
                end else begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= NOP_INSTR;
                    if_id_pc4   <= 32'h0;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, streaming, stall/skid, redirect, async reset, PC wrap.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;

    logic        rst_b;
    logic        id_stall_b;
    logic        redirect_valid_b;
    logic [31:0] redirect_target_b;
    logic        if_id_valid_b;
    logic [31:0] if_id_instr_b;
    logic [31:0] if_id_pc4_b;

    int          vec_cnt;
    int          err_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] cur_exp;

    if_fetch_stage_if #(.IMEM_AW(8)) bus_a ();
    if_fetch_stage_if #(.IMEM_AW(8)) bus_b ();

    if_fetch_stage #(.PC_RESET(32'h0000_0000), .IMEM_AW(8)) dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem            (bus_a),
        .id_stall        (id_stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4)
    );

    if_fetch_stage #(.PC_RESET(32'hFFFF_FFF8), .IMEM_AW(8)) dut_b (
        .clk             (clk),
        .rst_n           (rst_b),
        .imem            (bus_b),
        .id_stall        (id_stall_b),
        .redirect_valid  (redirect_valid_b),
        .redirect_target (redirect_target_b),
        .if_id_valid     (if_id_valid_b),
        .if_id_instr     (if_id_instr_b),
        .if_id_pc4       (if_id_pc4_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous memory models: word k holds 32'h2000_0000 | k
    always @(posedge clk) if (bus_a.en) bus_a.rdata <= 32'h2000_0000 | {24'h0, bus_a.addr};
    always @(posedge clk) if (bus_b.en) bus_b.rdata <= 32'h2000_0000 | {24'h0, bus_b.addr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check at the falling edge, return just after the next rising edge.
    task automatic step(input logic stall, input logic redir, input logic [31:0] tgt,
                        input logic exp_en, input logic [7:0] exp_addr,
                        input logic exp_valid, input logic exp_new);
        id_stall        = stall;
        redirect_valid  = redir;
        redirect_target = tgt;
        @(negedge clk);
        chk("imem_en", {31'h0, bus_a.en}, {31'h0, exp_en});
        if (exp_en) chk("imem_addr", {24'h0, bus_a.addr}, {24'h0, exp_addr});
        chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, exp_valid});
        if (exp_valid) begin
            if (exp_new) begin
                if (exp_q.size() == 0) chk("sb_empty", 32'h1, 32'h0);
                else cur_exp = exp_q.pop_front();
            end
            chk("if_id_instr", if_id_instr, cur_exp);
            chk("if_id_pc4", if_id_pc4, ((cur_exp & 32'hFF) << 2) + 32'd4);
        end else begin
            chk("nop_instr", if_id_instr, 32'h0);
            chk("nop_pc4", if_id_pc4, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  b_addr[5];
        logic [31:0] b_pc4[3];
        vec_cnt = 0;
        err_cnt = 0;
        cur_exp = 32'h0;
        rst_n = 1'b0;
        rst_b = 1'b0;
        id_stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        id_stall_b = 1'b0;
        redirect_valid_b = 1'b0;
        redirect_target_b = 32'h0;
        b_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        b_pc4  = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        foreach (b_addr[i]) begin end
        // reset state
        @(negedge clk);
        chk("rst_en", {31'h0, bus_a.en}, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) exp_q.push_back(32'h2000_0000 | k);
        exp_q.push_back(32'h2000_0010);
        exp_q.push_back(32'h2000_0011);
        exp_q.push_back(32'h2000_0012);
        exp_q.push_back(32'h2000_0020);
        exp_q.push_back(32'h2000_0021);

        // streaming from reset
        step(0, 0, 32'h0, 1, 8'd0, 0, 0);
        step(0, 0, 32'h0, 1, 8'd1, 0, 0);
        for (int c = 2; c < 6; c++) step(0, 0, 32'h0, 1, 8'(c), 1, 1);
        // three-cycle stall; word 5 parks in the skid entry
        step(1, 0, 32'h0, 0, 8'd0, 1, 1);
        step(1, 0, 32'h0, 0, 8'd0, 1, 0);
        step(1, 0, 32'h0, 0, 8'd0, 1, 0);
        step(0, 0, 32'h0, 0, 8'd0, 1, 0);
        step(0, 0, 32'h0, 1, 8'd6, 1, 1);
        step(0, 0, 32'h0, 1, 8'd7, 0, 0);
        step(0, 0, 32'h0, 1, 8'd8, 1, 1);
        step(0, 0, 32'h0, 1, 8'd9, 1, 1);
        // redirect to 0x41 -> PC 0x40, word 16; word 9 discarded
        step(0, 1, 32'h0000_0041, 0, 8'd0, 1, 1);
        step(0, 0, 32'h0, 1, 8'd16, 0, 0);
        step(0, 0, 32'h0, 1, 8'd17, 0, 0);
        step(0, 0, 32'h0, 1, 8'd18, 1, 1);
        step(0, 0, 32'h0, 1, 8'd19, 1, 1);
        // stall fills the skid, then redirect+stall flushes everything
        step(1, 0, 32'h0, 0, 8'd0, 1, 1);
        step(1, 1, 32'h0000_0080, 0, 8'd0, 1, 0);
        step(1, 0, 32'h0, 0, 8'd0, 0, 0);
        step(0, 0, 32'h0, 1, 8'd32, 0, 0);
        step(0, 0, 32'h0, 1, 8'd33, 0, 0);
        step(0, 0, 32'h0, 1, 8'd34, 1, 1);
        step(1, 0, 32'h0, 0, 8'd0, 1, 1);
        chk("sb_drained", exp_q.size(), 32'h0);

        // asynchronous reset mid-stall with the skid entry full
        id_stall = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_en", {31'h0, bus_a.en}, 32'h0);
        chk("arst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("arst_instr", if_id_instr, 32'h0);
        chk("arst_pc4", if_id_pc4, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back(32'h2000_0000 | k);
        step(0, 0, 32'h0, 1, 8'd0, 0, 0);
        step(0, 0, 32'h0, 1, 8'd1, 0, 0);
        step(0, 0, 32'h0, 1, 8'd2, 1, 1);
        step(0, 0, 32'h0, 1, 8'd3, 1, 1);
        step(0, 0, 32'h0, 1, 8'd4, 1, 1);

        // PC wrap from 32'hFFFF_FFF8
        rst_b = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("wrap_en", {31'h0, bus_b.en}, 32'h1);
            chk("wrap_addr", {24'h0, bus_b.addr}, {24'h0, b_addr[c]});
            if (c >= 2) begin
                chk("wrap_valid", {31'h0, if_id_valid_b}, 32'h1);
                chk("wrap_instr", if_id_instr_b, 32'h2000_0000 | {24'h0, b_addr[c-2]});
                chk("wrap_pc4", if_id_pc4_b, b_pc4[c-2]);
            end else begin
                chk("wrap_valid", {31'h0, if_id_valid_b}, 32'h0);
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
